// File: rtl/hazard_stall_unit_pkg.sv
// Shared types and constants for the ID-stage hazard/stall controller.
package hazard_stall_unit_pkg;

   localparam int REG_ADDR_W_DEF = 5;

   typedef enum logic {
      RUN  = 1'b0,
      HOLD = 1'b1
   } hz_state_t;

   // Number of stall cycles a detected hazard requires.
   localparam logic [1:0] NEED_0 = 2'd0;
   localparam logic [1:0] NEED_1 = 2'd1;
   localparam logic [1:0] NEED_2 = 2'd2;

endpackage

// File: rtl/hazard_stall_unit_if.sv
// Pipeline <-> hazard unit signal bundle. stall_cnt/flush_cnt exist only with HAZARD_STATS_EN.
interface hazard_stall_unit_if #(
   parameter int REG_ADDR_W = hazard_stall_unit_pkg::REG_ADDR_W_DEF
`ifdef HAZARD_STATS_EN
   , parameter int STAT_W = 16
`endif
);
   logic [REG_ADDR_W-1:0] ID_rs, ID_rt, EXE_writeSrc, MEM_writeSrc;
   logic ID_useRs, ID_useRt, ID_isBranch;
   logic EXE_RegWrite, EXE_MemRead, MEM_RegWrite, MEM_MemRead;
   logic ctrl_taken;
   logic PC_Write, IF_ID_Write, ID_EXE_Bubble, IF_ID_Flush, stalling;
`ifdef HAZARD_STATS_EN
   logic [STAT_W-1:0] stall_cnt, flush_cnt;
`endif

   // Pipeline side
   modport master (
      output ID_rs, ID_rt, ID_useRs, ID_useRt, ID_isBranch,
             EXE_writeSrc, EXE_RegWrite, EXE_MemRead,
             MEM_writeSrc, MEM_RegWrite, MEM_MemRead, ctrl_taken,
      input  PC_Write, IF_ID_Write, ID_EXE_Bubble, IF_ID_Flush, stalling
`ifdef HAZARD_STATS_EN
      , input stall_cnt, flush_cnt
`endif
   );

   // Hazard unit side
   modport slave (
      input  ID_rs, ID_rt, ID_useRs, ID_useRt, ID_isBranch,
             EXE_writeSrc, EXE_RegWrite, EXE_MemRead,
             MEM_writeSrc, MEM_RegWrite, MEM_MemRead, ctrl_taken,
      output PC_Write, IF_ID_Write, ID_EXE_Bubble, IF_ID_Flush, stalling
`ifdef HAZARD_STATS_EN
      , output stall_cnt, flush_cnt
`endif
   );
endinterface

// File: rtl/hazard_stall_unit_match.sv
// Combinational producer/consumer dependency check for one downstream stage.
module hazard_match #(
   parameter int REG_ADDR_W = 5
) (
   input  logic [REG_ADDR_W-1:0] i_rs,
   input  logic [REG_ADDR_W-1:0] i_rt,
   input  logic                  i_use_rs,
   input  logic                  i_use_rt,
   input  logic [REG_ADDR_W-1:0] i_wr_src,
   input  logic                  i_reg_write,
   output logic                  o_match
);
   logic w_hit_rs, w_hit_rt;

   // Address compares are gated by the use flags so unused fields never matter.
   assign w_hit_rs = i_use_rs && (i_wr_src == i_rs);
   assign w_hit_rt = i_use_rt && (i_wr_src == i_rt);
   assign o_match  = i_reg_write && (i_wr_src != '0) && (w_hit_rs || w_hit_rt);
endmodule

// File: rtl/hazard_stall_unit.sv
// ID-stage hazard controller: load-use and branch-operand stalls, IF/ID flush.
// Optional HAZARD_STATS_EN adds saturating stall/flush counters.
module hazard_stall_unit
   import hazard_stall_unit_pkg::*;
#(
   parameter int REG_ADDR_W = REG_ADDR_W_DEF
`ifdef HAZARD_STATS_EN
   , parameter int STAT_W = 16
`endif
) (
   input  logic           CLK,
   input  logic           Reset,
   hazard_stall_unit_if.slave hz
);
   hz_state_t  r_state, w_state_nxt;
   logic [1:0] r_remain, w_remain_nxt;
   logic [1:0] w_need;
   logic       w_match_exe, w_match_mem, w_stall, w_flush;

   hazard_match #(.REG_ADDR_W(REG_ADDR_W)) u_match_exe (
      .i_rs(hz.ID_rs), .i_rt(hz.ID_rt), .i_use_rs(hz.ID_useRs), .i_use_rt(hz.ID_useRt),
      .i_wr_src(hz.EXE_writeSrc), .i_reg_write(hz.EXE_RegWrite), .o_match(w_match_exe)
   );

   hazard_match #(.REG_ADDR_W(REG_ADDR_W)) u_match_mem (
      .i_rs(hz.ID_rs), .i_rt(hz.ID_rt), .i_use_rs(hz.ID_useRs), .i_use_rt(hz.ID_useRt),
      .i_wr_src(hz.MEM_writeSrc), .i_reg_write(hz.MEM_RegWrite), .o_match(w_match_mem)
   );

   always_comb begin
      w_need = NEED_0;
      if (hz.ID_isBranch && hz.EXE_MemRead && w_match_exe)      w_need = NEED_2;
      else if (hz.ID_isBranch && w_match_exe)                   w_need = NEED_1;
      else if (hz.ID_isBranch && hz.MEM_MemRead && w_match_mem) w_need = NEED_1;
      else if (!hz.ID_isBranch && hz.EXE_MemRead && w_match_exe) w_need = NEED_1;
   end

   // Single-cycle needs stay in RUN: the next cycle re-evaluates with advanced stages.
   always_comb begin
      w_state_nxt  = r_state;
      w_remain_nxt = r_remain;
      w_stall      = 1'b0;
      case (r_state)
         RUN: begin
            if (w_need != NEED_0) begin
               w_stall = 1'b1;
               if (w_need == NEED_2) begin
                  w_state_nxt  = HOLD;
                  w_remain_nxt = w_need - 2'd1;
               end
            end
         end
         HOLD: begin
            w_stall      = 1'b1;
            w_remain_nxt = r_remain - 2'd1;
            if (r_remain == 2'd1) w_state_nxt = RUN;
         end
         default: w_state_nxt = RUN;
      endcase
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         r_state  <= RUN;
         r_remain <= 2'd0;
      end else begin
         r_state  <= w_state_nxt;
         r_remain <= w_remain_nxt;
      end
   end

   // Stall wins over ctrl_taken: a branch resolved on stale operands is ignored.
   assign w_flush = !Reset && !w_stall && hz.ctrl_taken;

   always_comb begin
      hz.PC_Write      = 1'b1;
      hz.IF_ID_Write   = 1'b1;
      hz.ID_EXE_Bubble = 1'b0;
      hz.stalling      = 1'b0;
      hz.IF_ID_Flush   = w_flush;
      if (!Reset && w_stall) begin
         hz.PC_Write      = 1'b0;
         hz.IF_ID_Write   = 1'b0;
         hz.ID_EXE_Bubble = 1'b1;
         hz.stalling      = 1'b1;
      end
   end

`ifdef HAZARD_STATS_EN
   logic [STAT_W-1:0] r_stall_cnt, r_flush_cnt;

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
         if (w_flush && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
      end
   end

   assign hz.stall_cnt = r_stall_cnt;
   assign hz.flush_cnt = r_flush_cnt;
`endif
endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed self-checking bench for hazard_stall_unit; outputs sampled mid-cycle.
module tb_hazard_stall_unit;
   logic CLK = 1'b0;
   logic Reset;
   int   n_chk = 0;
   int   n_fail = 0;

   // {PC_Write, IF_ID_Write, ID_EXE_Bubble, IF_ID_Flush, stalling}
   localparam logic [4:0] O_RUN   = 5'b11000;
   localparam logic [4:0] O_FLUSH = 5'b11010;
   localparam logic [4:0] O_STALL = 5'b00101;

   hazard_stall_unit_if #(.REG_ADDR_W(5)) hz();

   hazard_stall_unit #(.REG_ADDR_W(5)) dut (
      .CLK   (CLK),
      .Reset (Reset),
      .hz    (hz)
   );

   always #5 CLK = ~CLK;

   logic [4:0] obs;
   assign obs = {hz.PC_Write, hz.IF_ID_Write, hz.ID_EXE_Bubble, hz.IF_ID_Flush, hz.stalling};

   task automatic clear_inputs();
      hz.ID_rs = '0; hz.ID_rt = '0; hz.ID_useRs = 1'b0; hz.ID_useRt = 1'b0;
      hz.ID_isBranch = 1'b0; hz.ctrl_taken = 1'b0;
      hz.EXE_writeSrc = '0; hz.EXE_RegWrite = 1'b0; hz.EXE_MemRead = 1'b0;
      hz.MEM_writeSrc = '0; hz.MEM_RegWrite = 1'b0; hz.MEM_MemRead = 1'b0;
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      clear_inputs();
      // load-use hazard present while in reset must not stall
      hz.ID_rs = 5'd8; hz.ID_useRs = 1'b1; hz.ctrl_taken = 1'b1;
      hz.EXE_writeSrc = 5'd8; hz.EXE_RegWrite = 1'b1; hz.EXE_MemRead = 1'b1;
      @(negedge CLK); #1;
      n_chk++;
      if (obs !== O_RUN) begin n_fail++; $display("FAIL reset_outputs: got %b want %b", obs, O_RUN); end
`ifdef HAZARD_STATS_EN
      n_chk++;
      if (hz.stall_cnt !== 16'd0 || hz.flush_cnt !== 16'd0) begin
         n_fail++; $display("FAIL reset_stats: got %0d/%0d want 0/0", hz.stall_cnt, hz.flush_cnt);
      end
`endif
      @(negedge CLK);
      clear_inputs();
      Reset = 1'b0;
   endtask

   task automatic test_load_use();
      @(negedge CLK); clear_inputs();
      hz.ID_rs = 5'd8; hz.ID_useRs = 1'b1;
      hz.EXE_writeSrc = 5'd8; hz.EXE_RegWrite = 1'b1; hz.EXE_MemRead = 1'b1;
      #1; n_chk++;
      if (obs !== O_STALL) begin n_fail++; $display("FAIL load_use_stall: got %b want %b", obs, O_STALL); end
      // lw advanced to MEM, bubble in EXE: forwarding handles it
      @(negedge CLK); clear_inputs();
      hz.ID_rs = 5'd8; hz.ID_useRs = 1'b1;
      hz.MEM_writeSrc = 5'd8; hz.MEM_RegWrite = 1'b1; hz.MEM_MemRead = 1'b1;
      #1; n_chk++;
      if (obs !== O_RUN) begin n_fail++; $display("FAIL load_use_release: got %b want %b", obs, O_RUN); end
   endtask

   task automatic test_branch_alu();
      @(negedge CLK); clear_inputs();
      hz.ID_isBranch = 1'b1; hz.ID_rs = 5'd9; hz.ID_useRs = 1'b1; hz.ctrl_taken = 1'b1;
      hz.EXE_writeSrc = 5'd9; hz.EXE_RegWrite = 1'b1;
      #1; n_chk++;
      if (obs !== O_STALL) begin n_fail++; $display("FAIL branch_alu_stall_beats_taken: got %b want %b", obs, O_STALL); end
      @(negedge CLK); clear_inputs();
      hz.ID_isBranch = 1'b1; hz.ID_rs = 5'd9; hz.ID_useRs = 1'b1; hz.ctrl_taken = 1'b1;
      hz.MEM_writeSrc = 5'd9; hz.MEM_RegWrite = 1'b1;
      #1; n_chk++;
      if (obs !== O_FLUSH) begin n_fail++; $display("FAIL branch_alu_resolve_flush: got %b want %b", obs, O_FLUSH); end
   endtask

   task automatic test_branch_load();
      @(negedge CLK); clear_inputs();
      hz.ID_isBranch = 1'b1; hz.ID_rt = 5'd10; hz.ID_useRt = 1'b1;
      hz.EXE_writeSrc = 5'd10; hz.EXE_RegWrite = 1'b1; hz.EXE_MemRead = 1'b1;
      #1; n_chk++;
      if (obs !== O_STALL) begin n_fail++; $display("FAIL branch_load_stall1: got %b want %b", obs, O_STALL); end
      // second cycle must hold regardless of inputs
      @(negedge CLK); clear_inputs(); hz.ctrl_taken = 1'b1;
      #1; n_chk++;
      if (obs !== O_STALL) begin n_fail++; $display("FAIL branch_load_stall2: got %b want %b", obs, O_STALL); end
      @(negedge CLK); clear_inputs();
      #1; n_chk++;
      if (obs !== O_RUN) begin n_fail++; $display("FAIL branch_load_release: got %b want %b", obs, O_RUN); end
      // branch reading a load still in MEM: one cycle
      @(negedge CLK); clear_inputs();
      hz.ID_isBranch = 1'b1; hz.ID_rs = 5'd11; hz.ID_useRs = 1'b1;
      hz.MEM_writeSrc = 5'd11; hz.MEM_RegWrite = 1'b1; hz.MEM_MemRead = 1'b1;
      #1; n_chk++;
      if (obs !== O_STALL) begin n_fail++; $display("FAIL branch_mem_load_stall: got %b want %b", obs, O_STALL); end
      @(negedge CLK); clear_inputs();
      #1; n_chk++;
      if (obs !== O_RUN) begin n_fail++; $display("FAIL branch_mem_load_release: got %b want %b", obs, O_RUN); end
   endtask

   task automatic test_zero_and_flags();
      @(negedge CLK); clear_inputs();
      hz.ID_rs = 5'd0; hz.ID_useRs = 1'b1; hz.ID_isBranch = 1'b1;
      hz.EXE_writeSrc = 5'd0; hz.EXE_RegWrite = 1'b1; hz.EXE_MemRead = 1'b1;
      #1; n_chk++;
      if (obs !== O_RUN) begin n_fail++; $display("FAIL zero_reg_no_stall: got %b want %b", obs, O_RUN); end
      @(negedge CLK); clear_inputs();
      hz.ID_rs = 5'd3; hz.ID_useRs = 1'b1; hz.ID_rt = 5'd8; hz.ID_useRt = 1'b0;
      hz.EXE_writeSrc = 5'd8; hz.EXE_RegWrite = 1'b1; hz.EXE_MemRead = 1'b1;
      #1; n_chk++;
      if (obs !== O_RUN) begin n_fail++; $display("FAIL unused_rt_no_stall: got %b want %b", obs, O_RUN); end
      // ALU producer in EXE, non-branch consumer: forwardable
      @(negedge CLK); clear_inputs();
      hz.ID_rs = 5'd12; hz.ID_useRs = 1'b1;
      hz.EXE_writeSrc = 5'd12; hz.EXE_RegWrite = 1'b1;
      #1; n_chk++;
      if (obs !== O_RUN) begin n_fail++; $display("FAIL alu_forward_no_stall: got %b want %b", obs, O_RUN); end
      // load without RegWrite cannot hazard
      @(negedge CLK); clear_inputs();
      hz.ID_rt = 5'd13; hz.ID_useRt = 1'b1;
      hz.EXE_writeSrc = 5'd13; hz.EXE_RegWrite = 1'b0; hz.EXE_MemRead = 1'b1;
      #1; n_chk++;
      if (obs !== O_RUN) begin n_fail++; $display("FAIL no_regwrite_no_stall: got %b want %b", obs, O_RUN); end
   endtask

   task automatic test_jump();
      @(negedge CLK); clear_inputs(); hz.ctrl_taken = 1'b1;
      #1; n_chk++;
      if (obs !== O_FLUSH) begin n_fail++; $display("FAIL jump_flush: got %b want %b", obs, O_FLUSH); end
      @(negedge CLK); clear_inputs();
      #1; n_chk++;
      if (obs !== O_RUN) begin n_fail++; $display("FAIL jump_after: got %b want %b", obs, O_RUN); end
   endtask

   task automatic test_reset_mid_hold();
`ifdef HAZARD_STATS_EN
      // stalls: 1+1+2+1 = 5; flushes: branch_alu + jump = 2
      n_chk++;
      if (hz.stall_cnt !== 16'd5 || hz.flush_cnt !== 16'd2) begin
         n_fail++; $display("FAIL stats_counts: got %0d/%0d want 5/2", hz.stall_cnt, hz.flush_cnt);
      end
`endif
      @(negedge CLK); clear_inputs();
      hz.ID_isBranch = 1'b1; hz.ID_rt = 5'd10; hz.ID_useRt = 1'b1;
      hz.EXE_writeSrc = 5'd10; hz.EXE_RegWrite = 1'b1; hz.EXE_MemRead = 1'b1;
      #1; n_chk++;
      if (obs !== O_STALL) begin n_fail++; $display("FAIL mid_hold_stall1: got %b want %b", obs, O_STALL); end
      Reset = 1'b1;
      #1; n_chk++;
      if (obs !== O_RUN) begin n_fail++; $display("FAIL mid_hold_reset_now: got %b want %b", obs, O_RUN); end
      @(negedge CLK); clear_inputs(); Reset = 1'b0;
      #1; n_chk++;
      if (obs !== O_RUN) begin n_fail++; $display("FAIL mid_hold_aborted: got %b want %b", obs, O_RUN); end
`ifdef HAZARD_STATS_EN
      n_chk++;
      if (hz.stall_cnt !== 16'd0 || hz.flush_cnt !== 16'd0) begin
         n_fail++; $display("FAIL stats_cleared: got %0d/%0d want 0/0", hz.stall_cnt, hz.flush_cnt);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_branch_alu();
      test_branch_load();
      test_zero_and_flags();
      test_jump();
      test_reset_mid_hold();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
